alu_chain_seq: RTL and testbench

Multi-byte operation sequencer wrapped around the 8-bit ALU. It accepts an operation on operands of up to `MAX_BYTES` bytes and issues one byte per cycle to the ALU. It chains ALU carry-out into the next byte's carry-in and assembles the wide result and flags. It sits directly upstream and downstream of the ALU: it drives every ALU input and consumes every ALU output. The ALU's outputs are registered, one cycle after inputs are presented with RDY high.

---
 rtl/alu_chain_seq_pkg.sv | 22 ++
 rtl/alu_chain_seq_if.sv | 45 ++++
 rtl/alu_chain_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_alu_chain_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_chain_seq_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: op codes, FSM states, default sizing.
package alu_chain_seq_pkg;

    localparam int MAX_BYTES = 4;
    localparam int LW        = 2;

    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_ASL  = 4'b1011;
    localparam logic [3:0] OP_OR   = 4'b1100;
    localparam logic [3:0] OP_AND  = 4'b1101;
    localparam logic [3:0] OP_XOR  = 4'b1110;
    localparam logic [3:0] OP_PASS = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_chain_seq_if.sv
// Request/response bus of the sequencer plus the byte-wide link to the 8-bit ALU.
interface alu_chain_seq_if #(
    parameter int MAX_BYTES = alu_chain_seq_pkg::MAX_BYTES,
    parameter int LW        = alu_chain_seq_pkg::LW
);
    localparam int W = 8 * MAX_BYTES;

    logic          start;
    logic          ready;
    logic [3:0]    op;
    logic          right;
    logic          bcd;
    logic          ci;
    logic [LW-1:0] len;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  result;
    logic          co, v, z, n, hc;
    logic          done;

    logic [3:0]    alu_op;
    logic          alu_right;
    logic [7:0]    alu_ai;
    logic [7:0]    alu_bi;
    logic          alu_ci;
    logic          alu_bcd;
    logic          alu_rdy;
    logic [7:0]    alu_out;
    logic          alu_co, alu_v, alu_z, alu_n, alu_hc;

    modport slave (
        input  start, op, right, bcd, ci, len, a, b,
        input  alu_out, alu_co, alu_v, alu_z, alu_n, alu_hc,
        output ready, result, co, v, z, n, hc, done,
        output alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd, alu_rdy
    );

    modport master (
        output start, op, right, bcd, ci, len, a, b,
        output alu_out, alu_co, alu_v, alu_z, alu_n, alu_hc,
        input  ready, result, co, v, z, n, hc, done,
        input  alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd, alu_rdy
    );

endinterface

// File: rtl/alu_chain_seq.sv
// Multi-byte sequencer: issues one operand byte per cycle to an external registered 8-bit ALU,
// chains carry between bytes and assembles the wide result and flags.
module alu_chain_seq
    import alu_chain_seq_pkg::*;
#(
    parameter int MAX_BYTES = alu_chain_seq_pkg::MAX_BYTES,
    parameter int LW        = alu_chain_seq_pkg::LW
) (
    input  logic           clk,
    input  logic           reset_n,
    alu_chain_seq_if.slave bus
);
    localparam int W = 8 * MAX_BYTES;

    state_e        state_q, state_d;
    logic          right_q, right_d;
    logic          ci_q, ci_d;
    logic [LW-1:0] len_q, len_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] prev_idx_q, prev_idx_d;
    logic [W-1:0]  result_q, result_d;
    logic          co_q, co_d, v_q, v_d, z_q, z_d, n_q, n_d, hc_q, hc_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic [3:0]    alu_op_q, alu_op_d;
    logic          alu_right_q, alu_right_d;
    logic [7:0]    alu_ai_q, alu_ai_d;
    logic [7:0]    alu_bi_q, alu_bi_d;
    logic          alu_bcd_q, alu_bcd_d;
    logic          alu_rdy_q, alu_rdy_d;

    logic [LW-1:0] first_idx_s, next_idx_s;
    logic [W-1:0]  col_result_s;
    logic          col_z_s, col_n_s, col_v_s, col_hc_s;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_ISSUE;
                else           state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                if (cnt_q == len_q) state_d = ST_DRAIN;
                else                state_d = ST_ISSUE;
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Slot update for the ALU byte that was issued in the previous cycle
    always_comb begin
        col_result_s = result_q;
        col_result_s[8*int'(prev_idx_q) +: 8] = bus.alu_out;
        col_z_s = z_q & bus.alu_z;
        if (prev_idx_q == len_q) begin
            col_n_s = bus.alu_n;
            col_v_s = bus.alu_v;
        end else begin
            col_n_s = n_q;
            col_v_s = v_q;
        end
        if (prev_idx_q == {LW{1'b0}}) col_hc_s = bus.alu_hc;
        else                          col_hc_s = hc_q;
    end

    // FSM outputs and datapath next-state: request latch, byte issue, result collection
    always_comb begin
        right_d     = right_q;
        ci_d        = ci_q;
        len_d       = len_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        prev_idx_d  = prev_idx_q;
        result_d    = result_q;
        co_d        = co_q;
        v_d         = v_q;
        z_d         = z_q;
        n_d         = n_q;
        hc_d        = hc_q;
        alu_op_d    = alu_op_q;
        alu_right_d = alu_right_q;
        alu_ai_d    = alu_ai_q;
        alu_bi_d    = alu_bi_q;
        alu_bcd_d   = alu_bcd_q;
        done_d      = 1'b0;
        ready_d     = (state_d == ST_IDLE);
        alu_rdy_d   = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        first_idx_s = bus.right ? bus.len : {LW{1'b0}};
        next_idx_s  = right_q ? (idx_q - LW'(1)) : (idx_q + LW'(1));
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    right_d     = bus.right;
                    ci_d        = bus.ci;
                    len_d       = bus.len;
                    a_d         = bus.a;
                    b_d         = bus.b;
                    idx_d       = first_idx_s;
                    cnt_d       = {LW{1'b0}};
                    result_d    = {W{1'b0}};
                    co_d        = 1'b0;
                    v_d         = 1'b0;
                    z_d         = 1'b1;
                    n_d         = 1'b0;
                    hc_d        = 1'b0;
                    alu_op_d    = bus.right ? OP_PASS : bus.op;
                    alu_right_d = bus.right;
                    alu_bcd_d   = bus.bcd;
                    alu_ai_d    = bus.a[8*int'(first_idx_s) +: 8];
                    alu_bi_d    = bus.b[8*int'(first_idx_s) +: 8];
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_ISSUE: begin
                prev_idx_d = idx_q;
                if (cnt_q != {LW{1'b0}}) begin
                    result_d = col_result_s;
                    z_d      = col_z_s;
                    n_d      = col_n_s;
                    v_d      = col_v_s;
                    hc_d     = col_hc_s;
                end else begin
                    result_d = result_q;
                end
                if (cnt_q == len_q) begin
                    alu_ai_d = 8'h00;
                    alu_bi_d = 8'h00;
                end else begin
                    idx_d    = next_idx_s;
                    cnt_d    = cnt_q + LW'(1);
                    alu_ai_d = a_q[8*int'(next_idx_s) +: 8];
                    alu_bi_d = b_q[8*int'(next_idx_s) +: 8];
                end
            end
            ST_DRAIN: begin
                result_d    = col_result_s;
                z_d         = col_z_s;
                n_d         = col_n_s;
                v_d         = col_v_s;
                hc_d        = col_hc_s;
                co_d        = bus.alu_co;
                done_d      = 1'b1;
                alu_op_d    = 4'h0;
                alu_right_d = 1'b0;
                alu_bcd_d   = 1'b0;
            end
            ST_DONE: begin
                done_d = 1'b0;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            right_q     <= 1'b0;
            ci_q        <= 1'b0;
            len_q       <= {LW{1'b0}};
            a_q         <= {W{1'b0}};
            b_q         <= {W{1'b0}};
            idx_q       <= {LW{1'b0}};
            cnt_q       <= {LW{1'b0}};
            prev_idx_q  <= {LW{1'b0}};
            result_q    <= {W{1'b0}};
            co_q        <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            hc_q        <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            alu_op_q    <= 4'h0;
            alu_right_q <= 1'b0;
            alu_ai_q    <= 8'h00;
            alu_bi_q    <= 8'h00;
            alu_bcd_q   <= 1'b0;
            alu_rdy_q   <= 1'b0;
        end else begin
            right_q     <= right_d;
            ci_q        <= ci_d;
            len_q       <= len_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            prev_idx_q  <= prev_idx_d;
            result_q    <= result_d;
            co_q        <= co_d;
            v_q         <= v_d;
            z_q         <= z_d;
            n_q         <= n_d;
            hc_q        <= hc_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            alu_op_q    <= alu_op_d;
            alu_right_q <= alu_right_d;
            alu_ai_q    <= alu_ai_d;
            alu_bi_q    <= alu_bi_d;
            alu_bcd_q   <= alu_bcd_d;
            alu_rdy_q   <= alu_rdy_d;
        end
    end

    // Carry chain must see the previous byte's carry in the same cycle, so it stays combinational
    assign bus.alu_ci    = (state_q == ST_ISSUE) ? ((cnt_q == {LW{1'b0}}) ? ci_q : bus.alu_co) : 1'b0;

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.co        = co_q;
    assign bus.v         = v_q;
    assign bus.z         = z_q;
    assign bus.n         = n_q;
    assign bus.hc        = hc_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_right = alu_right_q;
    assign bus.alu_ai    = alu_ai_q;
    assign bus.alu_bi    = alu_bi_q;
    assign bus.alu_bcd   = alu_bcd_q;
    assign bus.alu_rdy   = alu_rdy_q;

endmodule

// File: tb/tb_alu_chain_seq.sv
// Scoreboard bench for alu_chain_seq with a behavioural registered 8-bit ALU attached.
module tb_alu_chain_seq;
    import alu_chain_seq_pkg::*;

    typedef struct packed {
        logic [31:0] result;
        logic        co, v, z, n, hc;
    } exp_t;

    logic clk;
    logic reset_n;
    logic cur_right;
    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];

    alu_chain_seq_if bus ();

    alu_chain_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Byte ALU: returns {out[7:0], co, v, z, n, hc}
    function automatic logic [12:0] alu_byte(input logic [3:0] op, input logic right,
                                             input logic [7:0] ai, input logic [7:0] bi,
                                             input logic ci, input logic bcd);
        logic [7:0] bx, o;
        logic [4:0] tl, th;
        logic       c, vv, h;
        bx = bi; tl = 5'd0; th = 5'd0;
        if (right) begin
            o = {ci, ai[7:1]}; c = ai[0]; vv = 1'b0; h = 1'b0;
        end else if (op[3:2] == 2'b11) begin
            case (op[1:0])
                2'b00:   o = ai | bi;
                2'b01:   o = ai & bi;
                2'b10:   o = ai ^ bi;
                default: o = ai;
            endcase
            c = 1'b0; vv = 1'b0; h = 1'b0;
        end else begin
            case (op)
                OP_SUB:  bx = ~bi;
                OP_ASL:  bx = ai;
                default: bx = bi;
            endcase
            tl = {1'b0, ai[3:0]} + {1'b0, bx[3:0]} + {4'b0, ci};
            h  = tl[4] | (bcd & (tl[3:1] >= 3'd5));
            th = {1'b0, ai[7:4]} + {1'b0, bx[7:4]} + {4'b0, h};
            c  = th[4] | (bcd & (th[3:1] >= 3'd5));
            o  = {th[3:0], tl[3:0]};
            vv = (ai[7] == bx[7]) && (o[7] != ai[7]);
        end
        return {o, c, vv, (o == 8'h00), o[7], h};
    endfunction

    // Registered ALU: outputs update one edge after inputs are presented with rdy high
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {bus.alu_out, bus.alu_co, bus.alu_v, bus.alu_z, bus.alu_n, bus.alu_hc} <= 13'h0;
        end else if (bus.alu_rdy) begin
            {bus.alu_out, bus.alu_co, bus.alu_v, bus.alu_z, bus.alu_n, bus.alu_hc} <=
                alu_byte(bus.alu_op, bus.alu_right, bus.alu_ai, bus.alu_bi, bus.alu_ci, bus.alu_bcd);
        end
    end

    // Wide-word reference for binary (non-BCD) operations
    function automatic exp_t model_exp(input logic [3:0] op, input logic right, input logic ci,
                                       input int len, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int          nb;
        logic [63:0] mask, am, bm, s;
        logic [4:0]  lo;
        e    = '0;
        nb   = (len + 1) * 8;
        mask = (64'h1 << nb) - 64'h1;
        am   = {32'h0, a} & mask;
        bm   = {32'h0, b} & mask;
        if (right) begin
            s    = (am >> 1) | ({63'h0, ci} << (nb - 1));
            e.co = am[0];
        end else if (op[3:2] == 2'b11) begin
            case (op)
                OP_OR:   s = am | bm;
                OP_AND:  s = am & bm;
                OP_XOR:  s = am ^ bm;
                default: s = am;
            endcase
        end else begin
            if (op == OP_SUB)      bm = ~bm & mask;
            else if (op == OP_ASL) bm = am;
            s    = am + bm + {63'h0, ci};
            e.co = s[nb];
            e.v  = (am[nb-1] == bm[nb-1]) && (s[nb-1] != am[nb-1]);
            lo   = {1'b0, am[3:0]} + {1'b0, bm[3:0]} + {4'b0, ci};
            e.hc = lo[4];
        end
        s        = s & mask;
        e.result = s[31:0];
        e.n      = s[nb-1];
        e.z      = (s == 64'h0);
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] r, input logic co, input logic v,
                                input logic z, input logic n, input logic hc);
        exp_t e;
        e.result = r; e.co = co; e.v = v; e.z = z; e.n = n; e.hc = hc;
        return e;
    endfunction

    // Rotations must drive the pass op code on every cycle the ALU is enabled
    always @(negedge clk) begin
        if (reset_n && bus.alu_rdy && cur_right) check_val("alu_op_rot", 64'(bus.alu_op), 64'(OP_PASS));
    end

    task automatic run_op(input logic [3:0] op, input logic right, input logic bcd, input logic ci,
                          input int len, input logic [31:0] a, input logic [31:0] b, input bit poke);
        int   edges;
        exp_t e;
        e = '0;
        bus.start = 1'b1; bus.op = op; bus.right = right; bus.bcd = bcd; bus.ci = ci;
        bus.len = 2'(len); bus.a = a; bus.b = b;
        cur_right = right;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        edges = 1;
        check_val("ready_busy", 64'(bus.ready), 64'(1'b0));
        while (!bus.done && edges < 40) begin
            if (poke && edges == 2) begin
                bus.start = 1'b1; bus.a = ~a; bus.op = OP_XOR;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        check_val("done_latency", 64'(edges), 64'(len + 3));
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 64'(1'b1), 64'(1'b0));
        end else begin
            e = sb_q.pop_front();
            check_val("result", 64'(bus.result), 64'(e.result));
            check_val("co", 64'(bus.co), 64'(e.co));
            check_val("v", 64'(bus.v), 64'(e.v));
            check_val("z", 64'(bus.z), 64'(e.z));
            check_val("n", 64'(bus.n), 64'(e.n));
            check_val("hc", 64'(bus.hc), 64'(e.hc));
        end
        @(negedge clk);
        cur_right = 1'b0;
        check_val("done_pulse", 64'(bus.done), 64'(1'b0));
        check_val("ready_back", 64'(bus.ready), 64'(1'b1));
        check_val("result_hold", 64'(bus.result), 64'(e.result));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val(tag, {bus.result, 19'h0, bus.co, bus.v, bus.z, bus.n, bus.hc, bus.done, bus.alu_rdy,
                        bus.alu_ci, bus.alu_right, bus.alu_bcd, bus.ready},
                  64'h1);
        check_val("rst_alu_drive", 64'({bus.alu_op, bus.alu_ai, bus.alu_bi}), 64'h0);
    endtask

    logic [3:0] ops [7];

    initial begin
        exp_t        e;
        logic [3:0]  rop;
        logic        rright, rci;
        int          rlen;
        logic [31:0] ra, rb;
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_ASL; ops[3] = OP_OR;
        ops[4] = OP_AND; ops[5] = OP_XOR; ops[6] = OP_PASS;
        clk = 1'b0; reset_n = 1'b0; cur_right = 1'b0; n_cmp = 0; n_bad = 0;
        bus.start = 1'b0; bus.op = 4'h0; bus.right = 1'b0; bus.bcd = 1'b0; bus.ci = 1'b0;
        bus.len = 2'd0; bus.a = 32'h0; bus.b = 32'h0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        reset_n = 1'b1;
        @(negedge clk);

        sb_q.push_back(mk(32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        run_op(OP_ADD, 1'b0, 1'b0, 1'b0, 1, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        sb_q.push_back(mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        run_op(OP_SUB, 1'b0, 1'b0, 1'b1, 3, 32'h0, 32'h1, 1'b0);
        sb_q.push_back(mk(32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        run_op(OP_ADD, 1'b1, 1'b0, 1'b1, 3, 32'h0000_0001, 32'h0, 1'b0);
        sb_q.push_back(mk(32'h0000_01AA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        run_op(OP_ADD, 1'b0, 1'b1, 1'b0, 1, 32'h0000_0099, 32'h0000_0001, 1'b0);
        sb_q.push_back(mk(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        run_op(OP_AND, 1'b0, 1'b0, 1'b0, 3, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0);
        sb_q.push_back(mk(32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        run_op(OP_ADD, 1'b0, 1'b0, 1'b0, 3, 32'h1234_5678, 32'h1111_1111, 1'b1);

        for (int i = 0; i < 24; i++) begin
            rop    = ops[$urandom_range(0, 6)];
            rright = ($urandom_range(0, 3) == 0);
            rci    = 1'($urandom_range(0, 1));
            rlen   = $urandom_range(0, 3);
            ra     = $urandom;
            rb     = $urandom;
            e      = model_exp(rop, rright, rci, rlen, ra, rb);
            sb_q.push_back(e);
            run_op(rop, rright, 1'b0, rci, rlen, ra, rb, 1'b0);
        end

        bus.start = 1'b1; bus.op = OP_ADD; bus.right = 1'b0; bus.ci = 1'b0; bus.len = 2'd3;
        bus.a = 32'h0101_0101; bus.b = 32'h0202_0202;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("no_done_after_rst", 64'(bus.done), 64'(1'b0));
            check_val("ready_after_rst", 64'(bus.ready), 64'(1'b1));
        end

        sb_q.push_back(model_exp(OP_SUB, 1'b0, 1'b1, 2, 32'h0012_3456, 32'h0000_0457));
        run_op(OP_SUB, 1'b0, 1'b0, 1'b1, 2, 32'h0012_3456, 32'h0000_0457, 1'b0);
        check_val("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
